// File: rtl/multdiv_sign_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_sign_ctrl
// Purpose  : Signed front end for an unsigned mult/div core; time-shares one
//            external negation unit across operand A, operand B and result.
// Revision : 1.0  initial release
// ============================================================================
module multdiv_sign_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic [WIDTH-1:0] neg_in,
  input  logic [WIDTH-1:0] neg_result,
  output logic             core_start,
  output logic             core_is_div,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic             core_ready,
  input  logic [WIDTH-1:0] core_result,
  input  logic             core_exception,
  output logic [WIDTH-1:0] result,
  output logic             result_ready,
  output logic             exception
);

  localparam logic [WIDTH-1:0] c_min_mag = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_zero    = '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NEG_A  = 3'd1,
    S_NEG_B  = 3'd2,
    S_LAUNCH = 3'd3,
    S_WAIT   = 3'd4,
    S_NEG_R  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_mag;
  logic             r_sign;
  logic             r_ovf;

  // A magnitude with the top bit set only fits when it is exactly -2^(W-1).
  function automatic logic ovf_flag(input logic [WIDTH-1:0] mag,
                                    input logic             raw,
                                    input logic             sign);
    return raw | (mag[WIDTH-1] & ~(sign & (mag == c_min_mag)));
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_b          <= c_zero;
      r_mag        <= c_zero;
      r_sign       <= 1'b0;
      r_ovf        <= 1'b0;
      busy         <= 1'b0;
      neg_in       <= c_zero;
      core_start   <= 1'b0;
      core_is_div  <= 1'b0;
      core_a       <= c_zero;
      core_b       <= c_zero;
      result       <= c_zero;
      result_ready <= 1'b0;
      exception    <= 1'b0;
    end else begin
      core_start   <= 1'b0;
      result_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_b         <= op_b;
            r_sign      <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            core_is_div <= is_div;
            core_a      <= op_a;
            core_b      <= op_b;
            exception   <= 1'b0;
            busy        <= 1'b1;
            if (is_div && (op_b == c_zero)) begin
              result       <= c_zero;
              exception    <= 1'b1;
              result_ready <= 1'b1;
              r_state      <= S_DONE;
            end else if (op_a[WIDTH-1]) begin
              neg_in  <= op_a;
              r_state <= S_NEG_A;
            end else if (op_b[WIDTH-1]) begin
              neg_in  <= op_b;
              r_state <= S_NEG_B;
            end else begin
              core_start <= 1'b1;
              r_state    <= S_LAUNCH;
            end
          end
        end

        S_NEG_A: begin
          core_a <= neg_result;
          if (r_b[WIDTH-1]) begin
            neg_in  <= r_b;
            r_state <= S_NEG_B;
          end else begin
            neg_in     <= c_zero;
            core_start <= 1'b1;
            r_state    <= S_LAUNCH;
          end
        end

        S_NEG_B: begin
          core_b     <= neg_result;
          neg_in     <= c_zero;
          core_start <= 1'b1;
          r_state    <= S_LAUNCH;
        end

        S_LAUNCH: begin
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (core_ready) begin
            r_mag <= core_result;
            r_ovf <= core_exception;
            if (r_sign) begin
              neg_in  <= core_result;
              r_state <= S_NEG_R;
            end else begin
              result       <= core_result;
              exception    <= ovf_flag(core_result, core_exception, 1'b0);
              result_ready <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end

        S_NEG_R: begin
          result       <= neg_result;
          exception    <= ovf_flag(r_mag, r_ovf, 1'b1);
          neg_in       <= c_zero;
          result_ready <= 1'b1;
          r_state      <= S_DONE;
        end

        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          neg_in  <= c_zero;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sign_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_sign_ctrl
// Purpose  : Randomised self-checking bench for multdiv_sign_ctrl with a
//            signed-arithmetic reference model and an unsigned core model.
// Revision : 1.0  initial release
// ============================================================================
module tb_multdiv_sign_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_div = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic [31:0] neg_in;
  logic [31:0] neg_result;
  logic        core_start;
  logic        core_is_div;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_ready = 1'b0;
  logic [31:0] core_result = '0;
  logic        core_exception = 1'b0;
  logic [31:0] result;
  logic        result_ready;
  logic        exception;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  always #5 clock = ~clock;

  assign neg_result = ~neg_in + 32'd1;

  multdiv_sign_ctrl #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .is_div         (is_div),
    .op_a           (op_a),
    .op_b           (op_b),
    .busy           (busy),
    .neg_in         (neg_in),
    .neg_result     (neg_result),
    .core_start     (core_start),
    .core_is_div    (core_is_div),
    .core_a         (core_a),
    .core_b         (core_b),
    .core_ready     (core_ready),
    .core_result    (core_result),
    .core_exception (core_exception),
    .result         (result),
    .result_ready   (result_ready),
    .exception      (exception)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'h8000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'd0;
      3:       v = $urandom_range(0, 40);
      4:       v = 32'd0 - $urandom_range(1, 40);
      5:       v = $urandom_range(0, 32'h0001_0000);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // One full operation; the core model answers `delay` cycles into WAIT.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic d,
                        input int delay, input logic poke);
    longint      sa, sb, p;
    logic [63:0] pv, full;
    logic [31:0] ma, mb, exp_res, cres;
    logic        exp_exc, cexc, sgn;
    int          n, k, m;

    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ma  = 32'(sa < 0 ? -sa : sa);
    mb  = 32'(sb < 0 ? -sb : sb);
    sgn = a[31] ^ b[31];
    n   = int'(a[31]) + int'(b[31]);

    if (d && b == 32'd0) begin
      exp_res = 32'd0;
      exp_exc = 1'b1;
    end else begin
      p       = d ? sa / sb : sa * sb;
      pv      = p;
      exp_res = pv[31:0];
      exp_exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end
    if (d) begin
      cres = (mb == 32'd0) ? 32'd0 : ma / mb;
      cexc = 1'b0;
    end else begin
      full = {32'd0, ma} * {32'd0, mb};
      cres = full[31:0];
      cexc = |full[63:32];
    end

    @(negedge clock);
    op_a = a; op_b = b; is_div = d; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 1;
    check("busy_after_accept", busy, 1);

    if (d && b == 32'd0) begin
      check("div0_core_start", core_start, 0);
      check("div0_ready", result_ready, 1);
      check("div0_result", result, exp_res);
      check("div0_exc", exception, exp_exc);
    end else begin
      if (a[31])      check("neg_in_a", neg_in, a);
      else if (b[31]) check("neg_in_b", neg_in, b);
      while (!core_start && k < 8) begin
        @(negedge clock);
        k++;
      end
      check("launch_latency", k, 1 + n);
      check("core_a", core_a, ma);
      check("core_b", core_b, mb);
      check("core_is_div", core_is_div, d);
      for (int i = 0; i <= delay; i++) begin
        @(negedge clock);
        start = poke && (i == 0);
        if (start) begin
          op_a = $urandom; op_b = $urandom; is_div = ~d;
        end
      end
      start = 1'b0;
      core_ready = 1'b1; core_result = cres; core_exception = cexc;
      @(negedge clock);
      core_ready = 1'b0; core_result = $urandom; core_exception = 1'b0;
      m = 1;
      while (!result_ready && m < 6) begin
        @(negedge clock);
        m++;
      end
      check("result_latency", m, 1 + int'(sgn));
      check("result", result, exp_res);
      check("exception", exception, exp_exc);
    end
    @(negedge clock);
    check("busy_idle", busy, 0);
    check("result_held", result, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_core_start", core_start, 0);
    check("rst_ready", result_ready, 0);
    check("rst_exc", exception, 0);
    check("rst_result", result, 0);
    check("rst_core_a", core_a, 0);
    check("rst_core_b", core_b, 0);
    check("rst_neg_in", neg_in, 0);
    reset = 1'b1;

    run_op(32'd3, 32'd5, 1'b0, 2, 1'b0);
    run_op(32'hFFFF_FFFD, 32'd5, 1'b0, 1, 1'b0);
    run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 0, 1'b0);
    run_op(32'd9, 32'd0, 1'b1, 0, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
    run_op(32'h8000_0000, 32'd1, 1'b0, 3, 1'b0);
    run_op(32'd100, 32'hFFFF_FFF6, 1'b1, 2, 1'b1);

    for (int t = 0; t < 60; t++)
      run_op(pick(), pick(), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
             1'($urandom_range(0, 1)));

    // stray core_ready while idle
    @(negedge clock);
    core_ready = 1'b1; core_result = 32'hDEAD_BEEF;
    @(negedge clock);
    core_ready = 1'b0;
    check("stray_ready", result_ready, 0);
    check("stray_busy", busy, 0);
    check("stray_result", result, last_res);

    // reset while waiting on the core, then a late core_ready
    @(negedge clock);
    op_a = 32'd3; op_b = 32'd5; is_div = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    core_ready = 1'b1; core_result = 32'd15;
    @(negedge clock);
    core_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_ready", result_ready, 0);
      check("midrst_idle", busy, 0);
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
